// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line to 4 x 64-bit memory burst adaptor
// Latches a line request in IDLE, plays it out as four beats, then pulses resp_o.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wbuf_q, wbuf_d;
  logic [255:0]   line_q, line_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wbuf_q  <= 256'd0;
      line_q  <= 256'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        // Write has priority over a simultaneous read.
        if (write_i) begin
          wbuf_d  = line_i;
          addr_d  = address_i & 32'hFFFF_FFE0;
          cnt_d   = 2'd0;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i & 32'hFFFF_FFE0;
          cnt_d   = 2'd0;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          for (int b = 0; b < 4; b++) begin
            if (cnt_q == 2'(b)) begin
              line_d[64*b +: 64] = burst_i;
            end
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter sits at 0 outside a burst, so burst_o shows buffer beat 0 when idle.
  always_comb begin
    burst_o = wbuf_q[63:0];
    case (cnt_q)
      2'd0: burst_o = wbuf_q[63:0];
      2'd1: burst_o = wbuf_q[127:64];
      2'd2: burst_o = wbuf_q[191:128];
      2'd3: burst_o = wbuf_q[255:192];
      default: burst_o = wbuf_q[63:0];
    endcase
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
// The bench acts as both cache and memory; expected lines come from a beat-level model.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests = 0;
  int fails = 0;
  logic [255:0] model_line = '0;
  logic [255:0] model_wline = '0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  // Ends in the DONE cycle with resp_o checked; lat = cycles until read_o rises.
  task automatic do_read(input logic [31:0] addr, input int lat, input bit fixed,
                         input int stall_pct, input bit stray_done);
    int n;
    int stalls;
    logic [63:0] beat;
    write_i = 1'b0; read_i = 1'b1; address_i = addr; resp_i = 1'b0;
    for (n = 1; n <= 4; n++) begin
      tick();
      if (read_o) break;
      chk("rd_wait_resp", resp_o, 1'b0);
    end
    chk("rd_latency", n, lat);
    chk("rd_addr", address_o, align(addr));
    chk("rd_write_o", write_o, 1'b0);
    address_i = $urandom;
    for (int k = 0; k < 4; k++) begin
      stalls = 0;
      while (stalls < 6 && $urandom_range(99) < stall_pct) begin
        resp_i = 1'b0; burst_i = {$urandom, $urandom};
        tick();
        stalls++;
        chk("rd_stall_read_o", read_o, 1'b1);
        chk("rd_stall_resp", resp_o, 1'b0);
      end
      beat = fixed ? 64'h1111_1111_1111_1111 * (k + 1) : {$urandom, $urandom};
      model_line[64*k +: 64] = beat;
      chk("rd_beat_read_o", read_o, 1'b1);
      resp_i = 1'b1; burst_i = beat;
      tick();
    end
    resp_i = stray_done;
    chk("rd_done_resp", resp_o, 1'b1);
    chk("rd_done_read_o", read_o, 1'b0);
    chk("rd_line", line_o, model_line);
  endtask

  // plen > 0 replays resp_i from pat (bit 0 first), otherwise random accepts.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int lat,
                          input bit rd_too, input logic [15:0] pat, input int plen);
    int n;
    int acc;
    int c;
    bit r;
    read_i = rd_too; write_i = 1'b1; line_i = line; address_i = addr; resp_i = 1'b0;
    for (n = 1; n <= 4; n++) begin
      tick();
      if (write_o) break;
      chk("wr_wait_resp", resp_o, 1'b0);
    end
    chk("wr_latency", n, lat);
    chk("wr_read_o", read_o, 1'b0);
    chk("wr_addr", address_o, align(addr));
    line_i = {8{$urandom}}; address_i = $urandom;
    acc = 0; c = 0;
    while (acc < 4 && c < 40) begin
      chk("wr_write_o", write_o, 1'b1);
      chk("wr_resp_early", resp_o, 1'b0);
      chk("wr_burst", burst_o, line[64*acc +: 64]);
      r = (plen > 0 && c < plen) ? pat[c] : (plen > 0 ? 1'b1 : 1'($urandom_range(1)));
      resp_i = r;
      tick();
      acc += int'(r);
      c++;
    end
    resp_i = 1'b0;
    chk("wr_done_resp", resp_o, 1'b1);
    chk("wr_done_write_o", write_o, 1'b0);
    chk("wr_line_kept", line_o, model_line);
    model_wline = line;
  endtask

  task automatic idle();
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    tick();
    chk("idle_resp", resp_o, 1'b0);
    chk("idle_read_o", read_o, 1'b0);
    chk("idle_write_o", write_o, 1'b0);
  endtask

  task automatic stray_idle(input int cycles);
    read_i = 1'b0; write_i = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      tick();
      chk("stray_read_o", read_o, 1'b0);
      chk("stray_write_o", write_o, 1'b0);
      chk("stray_resp", resp_o, 1'b0);
      chk("stray_burst", burst_o, model_wline[63:0]);
      chk("stray_line", line_o, model_line);
    end
    resp_i = 1'b0;
  endtask

  initial begin
    bit in_done;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    tick();
    tick();
    chk("rst_resp", resp_o, 1'b0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_addr", address_o, 32'd0);
    chk("rst_burst", burst_o, 64'd0);
    chk("rst_line", line_o, 256'd0);
    rst = 1'b0;
    tick();

    do_read(32'h0000_1234, 1, 1'b1, 0, 1'b0);
    chk("t1_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    idle();

    do_write(32'h0000_2047, {8{$urandom}}, 1, 1'b0, 16'b1011001, 7);
    idle();

    do_write(32'h0000_5555, {8{$urandom}}, 1, 1'b1, 16'd0, 0);
    idle();

    do_read(32'h0000_0100, 1, 1'b0, 0, 1'b0);
    do_write(32'h0000_0200, {8{$urandom}}, 2, 1'b0, 16'd0, 0);
    idle();

    do_read(32'h0000_0840, 1, 1'b0, 40, 1'b1);
    idle();
    stray_idle(3);

    read_i = 1'b1; write_i = 1'b0; address_i = 32'h0000_3300; resp_i = 1'b0;
    tick();
    chk("mr_read_o", read_o, 1'b1);
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    tick();
    burst_i = {$urandom, $urandom};
    tick();
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mr_read_o_low", read_o, 1'b0);
    chk("mr_line_clr", line_o, 256'd0);
    chk("mr_resp", resp_o, 1'b0);
    chk("mr_burst", burst_o, 64'd0);
    model_line = '0;
    model_wline = '0;
    read_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_read(32'h0000_3300, 1, 1'b0, 30, 1'b0);
    idle();

    in_done = 1'b0;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(1) == 1)
        do_read($urandom, in_done ? 2 : 1, 1'b0, 30, 1'($urandom_range(1)));
      else
        do_write($urandom, {8{$urandom}}, in_done ? 2 : 1, 1'($urandom_range(1)), 16'd0, 0);
      in_done = 1'b1;
      if ($urandom_range(2) == 0) begin
        idle();
        stray_idle(1);
        in_done = 1'b0;
      end
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
